// File: rtl/imm_extend_unit.sv
// -----------------------------------------------------------------------------
// imm_extend_unit
//
// Buffered immediate-extension stage between instruction decode and the ALU
// operand mux / branch adder. An IN_W-bit immediate is extended to OUT_W bits
// according to a 2-bit mode, then queued in a DEPTH-entry FIFO so decode can
// run ahead of a stalled consumer.
//
// Modes (in_mode):
//   2'b00  sign extend
//   2'b01  zero extend
//   2'b10  upper placement (LUI): immediate in the top IN_W bits, zeros below
//   2'b11  branch offset: sign extend then shift left by 2
//          (only with IMM_EXT_BRSHIFT_EN defined; otherwise same as 2'b00)
//
// Configuration macro: IMM_EXT_BRSHIFT_EN
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   producer has an immediate/mode pair
//   in_ready   unit can accept this cycle (registered state only)
//   in_imm     immediate, IN_W bits
//   in_mode    extension mode, 2 bits
//   out_valid  head entry valid
//   out_ready  consumer takes head entry
//   out_data   extended head entry, forced to 0 while empty
//   count      current FIFO occupancy
// -----------------------------------------------------------------------------
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    MODE_SIGN = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_LUI  = 2'b10,
    MODE_BR   = 2'b11
  } imm_mode_e;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  // NOTE: w_ext gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    w_ext = w_sext;
    unique case (imm_mode_e'(in_mode))
      MODE_SIGN: w_ext = w_sext;
      MODE_ZERO: w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      MODE_LUI:  w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRSHIFT_EN
      MODE_BR:   w_ext = w_sext << 2;
`else
      MODE_BR:   w_ext = w_sext;
`endif
      default:   w_ext = w_sext;
    endcase
  end

  // NOTE: the storage array has no reset; entries are only observable through
  // out_data, which is masked to zero whenever the pointers say it is empty.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= w_ext;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
      // increment wraps from DEPTH-1 to 0 without a compare.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

- Parametrised, buffered immediate-extension stage for the datapath; successor to the fixed 16-to-32 sign extender.
- Accepts an IN_W-bit immediate plus a 2-bit mode over a valid/ready handshake and extends it to OUT_W bits: sign, zero, upper-placement (LUI) or branch-offset.
- Results are queued in a DEPTH-entry FIFO so the decode stage can run ahead of a stalled consumer.
- Sits between instruction decode and the ALU operand mux / branch adder.

## Interface
- IN_W, default 16: immediate width; must be ≥ 2.
- OUT_W, default 32: result width; must be ≥ IN_W + 2.
- DEPTH, default 2: FIFO entries; power of two, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_imm/in_mode valid.
- in_ready  output  1  unit can accept this cycle.
- in_imm  input  IN_W  immediate, signed or unsigned according to mode.
- in_mode  input  2  00 sign, 01 zero, 10 LUI, 11 branch.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head entry.
- out_data  output  OUT_W  extended result.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Accept (push) occurs on a rising edge when in_valid && in_ready. The extended value is computed combinationally from in_imm/in_mode and written to the tail entry.
- Mode 00: bits [OUT_W-1:IN_W] = in_imm[IN_W-1]; low bits = in_imm.
- Mode 01: upper bits = 0; low bits = in_imm.
- Mode 10: in_imm occupies bits [OUT_W-1:OUT_W-IN_W]; lower bits = 0.
- Mode 11: sign-extend as mode 00, then shift left by 2, zero-filling bits [1:0]. Subject to the configuration macro below.
- Pop occurs on a rising edge when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on registered state; a pop in the same cycle does not free a slot for a push.
- out_valid = (count != 0).
- out_data = head entry while out_valid = 1; it is forced to 0 while out_valid = 0.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- A push while full cannot occur, because in_ready = 0.
- A pop while empty cannot occur, because out_valid = 0.
- Handshake rules:
  - in_imm and in_mode are sampled only on accept.
  - in_valid may be held high across stall cycles.
  - The producer must not withdraw or change data while in_valid = 1 and in_ready = 0.
  - out_data is stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - count = 0, both pointers = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1 from the first cycle after the reset edge.
  - Reset mid-operation discards all queued entries. Any handshake sampled in the reset cycle is ignored.
- Latency: an entry accepted at edge N appears on out_data with out_valid = 1 after edge N. There is no combinational in-to-out bypass.
- Throughput: one entry per cycle sustained while 0 < count < DEPTH and both sides are active.
- From full: a pop at edge N raises in_ready after edge N; the next push can occur at edge N+1.
- count updates on the same edge as the push/pop that changes it.

## Configuration
- IMM_EXT_BRSHIFT_EN defined: mode 11 behaves as the branch-offset mode (sign-extend, then <<2).
- IMM_EXT_BRSHIFT_EN undefined:
  - Mode 11 behaves identically to mode 00.
  - No shift logic is synthesised.
  - All other behaviour is unchanged.

## Test plan
- Sign mode, defaults: push 16'h7FFF then 16'hFDFF with out_ready = 1 -> out_data 32'h00007FFF, then 32'hFFFFFDFF, each one cycle after its accept.
- Zero mode: 16'hFDFF -> 32'h0000FDFF. LUI mode: 16'h1234 -> 32'h12340000.
- Branch mode, 16'hFFFF:
  - With IMM_EXT_BRSHIFT_EN -> 32'hFFFFFFFC.
  - Without -> 32'hFFFFFFFF.
  - With the macro, 16'h0001 -> 32'h00000004.
- Backpressure, DEPTH = 2, out_ready = 0, push A, B, C on consecutive cycles:
  - A and B are accepted; count = 2; in_ready = 0 while C is held.
  - Raise out_ready: A, then B, then C emerge in order; C is accepted the cycle after the first pop.
- Concurrent push and pop at count = 1 for 8 cycles: count stays 1, the pointers wrap, and the output sequence matches the input sequence.
- Reset mid-operation: with count = 2, assert rst_n = 0 for one edge -> count = 0, out_valid = 0, out_data = 0, in_ready = 1. No old entry reappears afterwards.
